// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: state encoding, default bus
// widths and a strobe-width helper.
package apb_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // One strobe bit per data byte
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_req_fifo.sv
// Synchronous request FIFO with show-ahead read port.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   push_i, push_data_i   write side (ignored while full)
//   pop_i, pop_data_o     read side; pop_data_o is the current head entry
//   full_o, empty_o       occupancy flags
module apb_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wptr_q;
  logic [PTR_W:0]   rptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal)
  assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign empty_o = (wptr_q == rptr_q);

  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rptr_q[PTR_W-1:0]];

  // Pointer update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (PTR_W+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (PTR_W+1)'(1);
    end
  end

  // Storage; contents need no reset since the pointers qualify them
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 requester: queues valid/ready requests, runs each one through the
// APB SETUP/ACCESS phases and returns one in-order response per request.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   req_*                          request channel (valid/ready) with write,
//                                  address, write data and strobes
//   rsp_*                          response channel (valid/ready) with read
//                                  data, slave error and timeout flags
//   psel_o .. pstrb_o, p*_i        APB4 requester interface
//   busy_o                         requests queued or a transfer in progress
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter  int unsigned REQ_DEPTH      = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned STRB_W         = strb_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // request channel
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_W-1:0]     req_strb_i,
  // response channel
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_slverr_o,
  output logic                  rsp_timeout_o,
  // APB requester
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [STRB_W-1:0]     pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  // status
  output logic                  busy_o
);

  localparam int unsigned PAYLOAD_W = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W;
  localparam int unsigned TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  apb_state_e            state_q;
  logic [TMO_W-1:0]      wait_cnt_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [PAYLOAD_W-1:0]  fifo_head;

  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic [STRB_W-1:0]     head_strb;

  apb_req_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (req_valid_i),
    .push_data_i ({req_write_i, req_addr_i, req_wdata_i, req_strb_i}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign {head_write, head_addr, head_wdata, head_strb} = fifo_head;

  // Pop when starting from IDLE or chaining straight out of a consumed response
  assign fifo_pop = !fifo_empty &&
                    ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready_i));

  assign req_ready_o = !fifo_full;
  assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;

  // Transfer sequencer with registered APB and response outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pstrb_o       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_slverr_o  <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q  <= ST_SETUP;
            psel_o   <= 1'b1;
            pwrite_o <= head_write;
            paddr_o  <= head_addr;
            pwdata_o <= head_write ? head_wdata : '0;
            pstrb_o  <= head_write ? head_strb : '0;
          end
        end

        ST_SETUP: begin
          state_q    <= ST_ACCESS;
          penable_o  <= 1'b1;
          wait_cnt_q <= '0;
        end

        ST_ACCESS: begin
          // pready is checked first so it wins over an expiring counter
          if (pready_i) begin
            state_q       <= ST_RESP;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
            rsp_slverr_o  <= pslverr_i;
            rsp_timeout_o <= 1'b0;
          end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == TMO_LAST)) begin
            state_q       <= ST_RESP;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= '0;
            rsp_slverr_o  <= 1'b1;
            rsp_timeout_o <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + TMO_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            if (!fifo_empty) begin
              state_q  <= ST_SETUP;
              psel_o   <= 1'b1;
              pwrite_o <= head_write;
              paddr_o  <= head_addr;
              pwdata_o <= head_write ? head_wdata : '0;
              pstrb_o  <= head_write ? head_strb : '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
